// File: rtl/l_type_pkg.sv
// l_type_pkg: shared types for the RV32I load align/extend path.
// Opcode, funct3 encodings and the extract result bundle.
package l_type_pkg;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_e;

  typedef struct packed {
    logic [31:0] data;
    logic        misaligned;
  } ld_res_t;

  function automatic logic [31:0] sext8(
    input logic [7:0] b
  );
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] sext16(
    input logic [15:0] h
  );
    return {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/l_type_extract.sv
// l_type_extract: combinational lane select, sign/zero extension
// and natural-alignment check for one load access.
module l_type_extract
  import l_type_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] drdata,
  output ld_res_t     res
);

  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic        is_lb;
  logic        is_lh;
  logic        is_lw;
  logic        is_lbu;
  logic        is_lhu;

  assign is_lb  = (funct3 == F3_LB);
  assign is_lh  = (funct3 == F3_LH);
  assign is_lw  = (funct3 == F3_LW);
  assign is_lbu = (funct3 == F3_LBU);
  assign is_lhu = (funct3 == F3_LHU);

  always_comb begin
    bsel = drdata[7:0];
    unique case (addr)
      2'd0: bsel = drdata[7:0];
      2'd1: bsel = drdata[15:8];
      2'd2: bsel = drdata[23:16];
      2'd3: bsel = drdata[31:24];
      default: bsel = drdata[7:0];
    endcase
  end

  // halfword lane ignores addr[0]; odd halves only raise misaligned
  assign hsel = addr[1] ? drdata[31:16]
                        : drdata[15:0];

  always_comb begin
    res = '0;
    unique case (1'b1)
      is_lb: begin
        res.data = sext8(bsel);
      end
      is_lbu: begin
        res.data = {24'd0, bsel};
      end
      is_lh: begin
        res.data       = sext16(hsel);
        res.misaligned = addr[0];
      end
      is_lhu: begin
        res.data       = {16'd0, hsel};
        res.misaligned = addr[0];
      end
      is_lw: begin
        res.data       = drdata;
        res.misaligned = |addr;
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/l_type.sv
// l_type: registered load-data align/extend stage between the
// data memory read port and the register-file write mux.
module l_type
  import l_type_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic [31:0]     daddr,
  input  logic [XLEN-1:0] drdata,
  output logic [XLEN-1:0] out,
  output logic            misaligned
);

  ld_res_t res;
  logic    is_load;
  logic    unused;

  assign is_load = (instr[6:0] == OPC_LOAD);
  assign unused  = ^{instr[31:15], instr[11:7],
                     daddr[31:2]};

  l_type_extract u_extract (
    .funct3 (instr[14:12]),
    .addr   (daddr[1:0]),
    .drdata (drdata),
    .res    (res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out        <= '0;
      misaligned <= 1'b0;
    end else if (is_load) begin
      out        <= res.data;
      misaligned <= res.misaligned;
    end else begin
      out        <= '0;
      misaligned <= 1'b0;
    end
  end

endmodule

// File: tb/tb_l_type.sv
// tb_l_type: directed and random checks of l_type against a
// behavioural load-alignment model.
module tb_l_type;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic [31:0] daddr = '0;
  logic [31:0] drdata = '0;
  logic [31:0] out;
  logic        misaligned;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] D0 = 32'h80FF_7F01;

  l_type dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .daddr      (daddr),
    .drdata     (drdata),
    .out        (out),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h",
               tag, obs, exp);
    end
  endtask

  function automatic void model(
    input  logic [31:0] i,
    input  logic [31:0] a,
    input  logic [31:0] d,
    output logic [31:0] o,
    output logic        m
  );
    int unsigned off;
    int unsigned b;
    int unsigned h;
    int v;
    o = 0;
    m = 0;
    if (i[6:0] != 7'd3) return;
    off = a % 4;
    b = (d >> (8 * off)) % 256;
    h = (d >> (16 * (off / 2))) % 65536;
    case (i[14:12])
      3'd0: begin
        v = b;
        if (v > 127) v = v - 256;
        o = v;
      end
      3'd1: begin
        v = h;
        if (v > 32767) v = v - 65536;
        o = v;
        m = (off % 2) != 0;
      end
      3'd2: begin
        o = d;
        m = off != 0;
      end
      3'd4: o = b;
      3'd5: begin
        o = h;
        m = (off % 2) != 0;
      end
      default: ;
    endcase
  endfunction

  task automatic step(
    input logic [31:0] i,
    input logic [31:0] a,
    input logic [31:0] d
  );
    instr  = i;
    daddr  = a;
    drdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic dir(
    input string       tag,
    input logic [31:0] i,
    input logic [31:0] a,
    input logic [31:0] eo,
    input logic        em
  );
    step(i, a, D0);
    chk({tag, ".out"}, out, eo);
    chk({tag, ".mis"}, {31'd0, misaligned},
        {31'd0, em});
  endtask

  initial begin
    logic [31:0] eo;
    logic        em;
    logic [31:0] ri;

    rst = 1'b1;
    step(32'h0000_2003, 32'd9, D0);
    chk("rst.out", out, 32'd0);
    chk("rst.mis", {31'd0, misaligned}, 32'd0);
    rst = 1'b0;

    dir("lw8",  32'h0000_2003, 32'd8, D0, 1'b0);
    dir("lw9",  32'h0000_2003, 32'd9, D0, 1'b1);
    dir("lb0",  32'h0000_0003, 32'd0, 32'h0000_0001, 1'b0);
    dir("lb2",  32'h0000_0003, 32'd2, 32'hFFFF_FFFF, 1'b0);
    dir("lb3",  32'h0000_0003, 32'd3, 32'hFFFF_FF80, 1'b0);
    dir("lbu3", 32'h0000_4003, 32'd3, 32'h0000_0080, 1'b0);
    dir("lh0",  32'h0000_1003, 32'd0, 32'h0000_7F01, 1'b0);
    dir("lh2",  32'h0000_1003, 32'd2, 32'hFFFF_80FF, 1'b0);
    dir("lhu2", 32'h0000_5003, 32'd2, 32'h0000_80FF, 1'b0);
    dir("lh3",  32'h0000_1003, 32'd3, 32'hFFFF_80FF, 1'b1);
    dir("f3ill", 32'h0000_3003, 32'd0, 32'd0, 1'b0);
    dir("nold", 32'h0000_2033, 32'd0, 32'd0, 1'b0);

    // back-to-back: each result exactly one edge after its inputs
    step(32'h0000_2003, 32'd4, D0);
    instr = 32'h0000_0003;
    daddr = 32'd3;
    #1;
    chk("b2b.lw", out, D0);
    @(posedge clk);
    #1;
    chk("b2b.lb", out, 32'hFFFF_FF80);

    // mid-operation reset discards the pending load
    instr = 32'h0000_2003;
    daddr = 32'd0;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid", out, 32'd0);
    rst = 1'b0;

    for (int n = 0; n < 300; n++) begin
      ri = $urandom;
      if ($urandom_range(3) != 0)
        ri[6:0] = 7'b0000011;
      rst = ($urandom_range(19) == 0);
      instr  = ri;
      daddr  = $urandom;
      drdata = $urandom;
      if (rst) begin
        eo = 0;
        em = 0;
      end else begin
        model(instr, daddr, drdata, eo, em);
      end
      @(posedge clk);
      #1;
      chk("rnd.out", out, eo);
      chk("rnd.mis", {31'd0, misaligned},
          {31'd0, em});
      // inputs wander mid-cycle; output must hold
      instr  = $urandom;
      daddr  = $urandom;
      drdata = $urandom;
      #2;
      chk("rnd.hold", out, eo);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
